// File: rtl/opcode_pkg.sv
// rtl/opcode_pkg.sv - shared opcodes, ALUop codes, control bundle and FIFO state types
package opcode_pkg;

  localparam logic [5:0] OPC_RTYPE   = 6'b000000;
  localparam logic [5:0] OPC_ADDI    = 6'b000010;
  localparam logic [5:0] OPC_SUBI    = 6'b000011;
  localparam logic [5:0] OPC_ANDI    = 6'b000100;
  localparam logic [5:0] OPC_ORI     = 6'b000101;
  localparam logic [5:0] OPC_SLTI    = 6'b000111;
  localparam logic [5:0] OPC_LW      = 6'b001000;
  localparam logic [5:0] OPC_LB      = 6'b001001;
  localparam logic [5:0] OPC_SW      = 6'b010000;
  localparam logic [5:0] OPC_SB      = 6'b010001;
  localparam logic [5:0] OPC_BEQ     = 6'b100011;
  localparam logic [5:0] OPC_BNE     = 6'b100111;
  localparam logic [5:0] OPC_J       = 6'b111000;
  localparam logic [5:0] OPC_JAL     = 6'b111001;
  localparam logic [5:0] OPC_ILLEGAL = 6'b111111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_SUBN  = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam int PAYLOAD_W = 7;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       byte_ops;
    logic [2:0] alu_op;
    logic       move;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/opcode_fifo2.sv
// rtl/opcode_fifo2.sv - 2-entry valid/ready FIFO carrying opcode plus illegal flag
module opcode_fifo2
  import opcode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = PAYLOAD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  fifo_state_t  state_q, state_d;
  logic         wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         push, pop;

  assign out_valid = (state_q != FIFO_EMPTY);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = (state_q != FIFO_FULL) || pop;
  assign push      = in_valid && in_ready;
  assign out_data  = mem[rptr];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIFO_EMPTY: if (push) state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      state_d = FIFO_FULL;
        else if (pop && !push) state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop && !push) state_d = FIFO_ONE;
      default:    state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FIFO_EMPTY;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
    end
  end

endmodule

// File: rtl/opcode_encoder.sv
// rtl/opcode_encoder.sv - recovers the opcode from a control bundle and flags illegal bundles
// Statistics counters are built only when OPC_ENC_STATS_EN is defined.
module opcode_encoder
  import opcode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             regDst,
  input  logic             branch,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             ALUsrc,
  input  logic             regWrite,
  input  logic             jump,
  input  logic             byteOperations,
  input  logic             move,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic             out_illegal,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef OPC_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  ctrl_bundle_t bundle;
  logic [7:0]   flags;
  logic [5:0]   enc_opcode;
  logic         enc_illegal;
  logic         accept;

  assign bundle = {regDst, branch, memRead, memWrite, ALUsrc, regWrite,
                   jump, byteOperations, ALUop, move};
  assign flags  = {bundle.reg_dst, bundle.branch, bundle.mem_read, bundle.mem_write,
                   bundle.alu_src, bundle.reg_write, bundle.jump, bundle.byte_ops};
  assign accept = in_valid && in_ready;

  // R-type ignores move; every other legal bundle requires move=0.
  always_comb begin
    enc_opcode  = OPC_ILLEGAL;
    enc_illegal = 1'b1;
    if (flags == 8'b1000_0100 && bundle.alu_op == ALU_RTYPE) begin
      enc_opcode  = OPC_RTYPE;
      enc_illegal = 1'b0;
    end else if (!bundle.move) begin
      enc_illegal = 1'b0;
      case ({flags, bundle.alu_op})
        {8'b0000_1100, ALU_ADD}:  enc_opcode = OPC_ADDI;
        {8'b0000_1100, ALU_SUB}:  enc_opcode = OPC_SUBI;
        {8'b0000_1100, ALU_AND}:  enc_opcode = OPC_ANDI;
        {8'b0000_1100, ALU_OR}:   enc_opcode = OPC_ORI;
        {8'b0000_1100, ALU_SLT}:  enc_opcode = OPC_SLTI;
        {8'b0010_1100, ALU_ADD}:  enc_opcode = OPC_LW;
        {8'b0010_1101, ALU_ADD}:  enc_opcode = OPC_LB;
        {8'b0001_1000, ALU_ADD}:  enc_opcode = OPC_SW;
        {8'b0001_1001, ALU_ADD}:  enc_opcode = OPC_SB;
        {8'b0100_0000, ALU_SUB}:  enc_opcode = OPC_BEQ;
        {8'b0100_0000, ALU_SUBN}: enc_opcode = OPC_BNE;
        {8'b0000_0010, ALU_ADD}:  enc_opcode = OPC_J;
        {8'b0000_0110, ALU_ADD}:  enc_opcode = OPC_JAL;
        default: begin
          enc_opcode  = OPC_ILLEGAL;
          enc_illegal = 1'b1;
        end
      endcase
    end
  end

  opcode_fifo2 #(.DEPTH(DEPTH), .W(PAYLOAD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({enc_illegal, enc_opcode}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_illegal, out_opcode})
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                       err_sticky <= 1'b0;
    else if (accept && enc_illegal)   err_sticky <= 1'b1;
    else if (err_clr)                 err_sticky <= 1'b0;
  end

`ifdef OPC_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_cnt   <= '0;
      illegal_cnt <= '0;
    end else if (accept) begin
      if (total_cnt != '1) total_cnt <= total_cnt + 1'b1;
      if (enc_illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_opcode_encoder.sv
// tb/tb_opcode_encoder.sv - table-driven scoreboard bench for opcode_encoder
module tb_opcode_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_illegal, err_sticky, err_clr;
  logic        regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump, byteOperations, move;
  logic [2:0]  ALUop;
  logic [5:0]  out_opcode;
  logic [11:0] bun;
  logic [5:0]  exp_opc;
  logic        exp_ill;
  logic [6:0]  sb_q[$];
  logic [6:0]  sb_head;
  int          n_checks = 0;
  int          n_fail   = 0;
`ifdef OPC_ENC_STATS_EN
  logic [15:0] total_cnt, illegal_cnt;
`endif

  typedef struct {
    logic [11:0] bundle;
    logic [5:0]  opc;
    logic        ill;
  } vec_t;

  vec_t legal[15];
  vec_t illeg[6];

  always #5 clk = ~clk;

  assign {regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump, byteOperations, ALUop, move} = bun;

  opcode_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .regDst(regDst), .branch(branch), .memRead(memRead), .memWrite(memWrite),
    .ALUsrc(ALUsrc), .regWrite(regWrite), .jump(jump), .byteOperations(byteOperations),
    .move(move), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_illegal(out_illegal), .err_sticky(err_sticky),
    .err_clr(err_clr)
`ifdef OPC_ENC_STATS_EN
    , .total_cnt(total_cnt), .illegal_cnt(illegal_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation queued on accept, compared when the head leaves.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected no output", {out_illegal, out_opcode});
        end else begin
          sb_head = sb_q.pop_front();
          check("sb_out", 32'({out_illegal, out_opcode}), 32'(sb_head));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({exp_ill, exp_opc});
    end
  end

  task automatic push(input vec_t v);
    bun      = v.bundle;
    exp_opc  = v.opc;
    exp_ill  = v.ill;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_err_sticky"}, 32'(err_sticky), 0);
`ifdef OPC_ENC_STATS_EN
    check({tag, "_total_cnt"}, 32'(total_cnt), 0);
    check({tag, "_illegal_cnt"}, 32'(illegal_cnt), 0);
`endif
  endtask

  initial begin
    // {regDst,branch,memRead,memWrite,ALUsrc,regWrite,jump,byteOps, ALUop, move}
    legal[0]  = '{{8'b1000_0100, 3'b111, 1'b0}, 6'b000000, 1'b0};
    legal[1]  = '{{8'b0000_1100, 3'b000, 1'b0}, 6'b000010, 1'b0};
    legal[2]  = '{{8'b0000_1100, 3'b001, 1'b0}, 6'b000011, 1'b0};
    legal[3]  = '{{8'b0000_1100, 3'b010, 1'b0}, 6'b000100, 1'b0};
    legal[4]  = '{{8'b0000_1100, 3'b011, 1'b0}, 6'b000101, 1'b0};
    legal[5]  = '{{8'b0000_1100, 3'b100, 1'b0}, 6'b000111, 1'b0};
    legal[6]  = '{{8'b0010_1100, 3'b000, 1'b0}, 6'b001000, 1'b0};
    legal[7]  = '{{8'b0010_1101, 3'b000, 1'b0}, 6'b001001, 1'b0};
    legal[8]  = '{{8'b0001_1000, 3'b000, 1'b0}, 6'b010000, 1'b0};
    legal[9]  = '{{8'b0001_1001, 3'b000, 1'b0}, 6'b010001, 1'b0};
    legal[10] = '{{8'b0100_0000, 3'b001, 1'b0}, 6'b100011, 1'b0};
    legal[11] = '{{8'b0100_0000, 3'b101, 1'b0}, 6'b100111, 1'b0};
    legal[12] = '{{8'b0000_0010, 3'b000, 1'b0}, 6'b111000, 1'b0};
    legal[13] = '{{8'b0000_0110, 3'b000, 1'b0}, 6'b111001, 1'b0};
    legal[14] = '{{8'b1000_0100, 3'b111, 1'b1}, 6'b000000, 1'b0};
    illeg[0]  = '{{8'b0100_0000, 3'b001, 1'b1}, 6'b111111, 1'b1};
    illeg[1]  = '{{8'b0000_0000, 3'b000, 1'b0}, 6'b111111, 1'b1};
    illeg[2]  = '{{8'b1000_0100, 3'b000, 1'b0}, 6'b111111, 1'b1};
    illeg[3]  = '{{8'b0001_1100, 3'b000, 1'b0}, 6'b111111, 1'b1};
    illeg[4]  = '{{8'b0000_0010, 3'b000, 1'b1}, 6'b111111, 1'b1};
    illeg[5]  = '{{8'b0000_1100, 3'b110, 1'b0}, 6'b111111, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    bun = '0; exp_opc = '0; exp_ill = 1'b0;

    // Reset values, during reset and on the first cycle after it
    @(posedge clk); @(posedge clk); #1;
    check_idle_state("rst");
    check("rst_opcode", 32'(out_opcode), 0);
    check("rst_illegal", 32'(out_illegal), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_state("post_rst");
    @(posedge clk); #1;

    // Single addi: head valid one cycle after acceptance
    push(legal[1]);
    in_valid = 1'b0;
    check("addi_valid", 32'(out_valid), 1);
    check("addi_opcode", 32'(out_opcode), 32'(6'b000010));
    check("addi_illegal", 32'(out_illegal), 0);
    idle(2);

    // Legal table back-to-back (R-type with move=1 appended)
    do_reset();
    for (int i = 0; i < 14; i++) push(legal[i]);
    idle(3);
    check("legal_drained", 32'(sb_q.size()), 0);
`ifdef OPC_ENC_STATS_EN
    check("legal_total_cnt", 32'(total_cnt), 14);
    check("legal_illegal_cnt", 32'(illegal_cnt), 0);
`endif
    check("legal_err_sticky", 32'(err_sticky), 0);
    push(legal[14]);
    idle(2);
    check("rtype_move_err", 32'(err_sticky), 0);

    // Illegal bundles set err_sticky; set beats a simultaneous clear
    push(illeg[0]);
    in_valid = 1'b0;
    check("beq_move_opcode", 32'(out_opcode), 32'(6'b111111));
    check("beq_move_illegal", 32'(out_illegal), 1);
    check("beq_move_err", 32'(err_sticky), 1);
    for (int i = 1; i < 6; i++) push(illeg[i]);
    err_clr = 1'b1;
    push(illeg[1]);
    err_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_vs_set_err", 32'(err_sticky), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_err", 32'(err_sticky), 0);
    idle(2);

    // Backpressure: two accepted, third stalls, then pop-through at FULL
    out_ready = 1'b0;
    push(legal[6]);
    push(legal[7]);
    bun = legal[8].bundle; exp_opc = legal[8].opc; exp_ill = legal[8].ill;
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 0);
    check("full_head", 32'(out_opcode), 32'(6'b001000));
    @(posedge clk); #1;
    check("hold_head", 32'(out_opcode), 32'(6'b001000));
    check("hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("popthru_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("popthru_head", 32'(out_opcode), 32'(6'b001001));
    idle(3);
    check("bp_drained", 32'(sb_q.size()), 0);

    // Reset with two entries buffered discards them
    out_ready = 1'b0;
    push(legal[2]);
    push(illeg[1]);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 1);
    do_reset();
    check_idle_state("mid_rst");
    out_ready = 1'b1;
    idle(3);

`ifdef OPC_ENC_STATS_EN
    // Counter saturation
    for (int i = 0; i < 65536; i++) push(illeg[1]);
    idle(3);
    check("sat_illegal_cnt", 32'(illegal_cnt), 32'h0000_FFFF);
    check("sat_total_cnt", 32'(total_cnt), 32'h0000_FFFF);
`endif

    check("final_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
